// File: rtl/knight_animator.sv
// knight_animator: latches per-frame knight parameters on each VS rising edge,
// runs the animation-slot FSM at one frame advance every six frame ticks, and
// produces a registered in-box flag plus sprite ROM address for each pixel.
`default_nettype none

module knight_animator (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        VS,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  input  logic [9:0]  PlayerX,
  input  logic [9:0]  PlayerY,
  input  logic [9:0]  Player_Size_X,
  input  logic [9:0]  Player_Size_Y,
  input  logic [3:0]  Player_Status,
  input  logic        Inverse,
  output logic        is_knight,
  output logic [14:0] sprite_addr,
  output logic [3:0]  anim_slot
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WALK   = 3'd1,
    ST_JUMP   = 3'd2,
    ST_FALL   = 3'd3,
    ST_ATTACK = 3'd4
  } anim_state_t;

  // Map a raw status code to an animation state; illegal codes fall back to idle.
  function automatic anim_state_t decode_status(input logic [3:0] status);
    anim_state_t st;
    case (status)
      4'd0:    st = ST_IDLE;
      4'd1:    st = ST_WALK;
      4'd2:    st = ST_JUMP;
      4'd3:    st = ST_FALL;
      4'd4:    st = ST_ATTACK;
      default: st = ST_IDLE;
    endcase
    return st;
  endfunction

  logic        vs_r;
  logic        frame_tick_s;
  anim_state_t state_r;
  anim_state_t state_next_s;
  anim_state_t req_state_s;
  logic [1:0]  frame_r;
  logic [1:0]  frame_next_s;
  logic [2:0]  div_r;
  logic [2:0]  div_next_s;
  logic [3:0]  slot_next_s;

  logic        inv_r;
  logic [9:0]  pos_x_r;
  logic [9:0]  pos_y_r;
  logic [9:0]  size_x_r;
  logic [9:0]  size_y_r;

  logic [9:0]  half_x_s;
  logic [9:0]  half_y_s;
  logic [9:0]  left_s;
  logic [9:0]  top_s;
  logic [10:0] right_s;
  logic [10:0] bottom_s;
  logic        size_ok_s;
  logic        inside_s;
  logic [4:0]  dx_off_s;
  logic [4:0]  col_s;
  logic [5:0]  row_s;
  logic [14:0] addr_s;

  // Frame boundary detection: tick on the 0->1 transition of VS only.
  assign frame_tick_s = VS & ~vs_r;

  // VS history register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vs_r <= 1'b0;
    end else begin
      vs_r <= VS;
    end
  end

  // Snapshot the knight parameters at each frame boundary so a frame never tears.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      inv_r    <= 1'b0;
      pos_x_r  <= 10'd0;
      pos_y_r  <= 10'd0;
      size_x_r <= 10'd0;
      size_y_r <= 10'd0;
    end else if (frame_tick_s) begin
      inv_r    <= Inverse;
      pos_x_r  <= PlayerX;
      pos_y_r  <= PlayerY;
      size_x_r <= Player_Size_X;
      size_y_r <= Player_Size_Y;
    end
  end

  // Animation next-state: a state change restarts the sequence and wins over a divider rollover.
  always_comb begin
    state_next_s = state_r;
    frame_next_s = frame_r;
    div_next_s   = div_r;
    slot_next_s  = anim_slot;
    req_state_s  = decode_status(Player_Status);
    if (frame_tick_s) begin
      state_next_s = req_state_s;
      if (req_state_s != state_r) begin
        frame_next_s = 2'd0;
        div_next_s   = 3'd0;
      end else if (div_r == 3'd5) begin
        div_next_s = 3'd0;
        case (state_r)
          ST_IDLE:   frame_next_s = (frame_r >= 2'd1) ? 2'd0 : frame_r + 2'd1;
          ST_WALK:   frame_next_s = frame_r + 2'd1;
          ST_ATTACK: frame_next_s = (frame_r >= 2'd2) ? 2'd2 : frame_r + 2'd1;
          default:   frame_next_s = 2'd0;
        endcase
      end else begin
        div_next_s = div_r + 3'd1;
      end
      case (state_next_s)
        ST_IDLE:   slot_next_s = 4'd0 + {2'b00, frame_next_s};
        ST_WALK:   slot_next_s = 4'd2 + {2'b00, frame_next_s};
        ST_JUMP:   slot_next_s = 4'd6;
        ST_FALL:   slot_next_s = 4'd7;
        ST_ATTACK: slot_next_s = 4'd8 + {2'b00, frame_next_s};
        default:   slot_next_s = 4'd0;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Animation state, frame index, divider and registered slot.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_r   <= ST_IDLE;
      frame_r   <= 2'd0;
      div_r     <= 3'd0;
      anim_slot <= 4'd0;
    end else begin
      state_r   <= state_next_s;
      frame_r   <= frame_next_s;
      div_r     <= div_next_s;
      anim_slot <= slot_next_s;
    end
  end

  // Box geometry and pixel offsets from the latched parameters; edges clamp at 0.
  always_comb begin
    half_x_s  = {1'b0, size_x_r[9:1]};
    half_y_s  = {1'b0, size_y_r[9:1]};
    left_s    = (pos_x_r >= half_x_s) ? (pos_x_r - half_x_s) : 10'd0;
    top_s     = (pos_y_r >= half_y_s) ? (pos_y_r - half_y_s) : 10'd0;
    right_s   = {1'b0, left_s} + {1'b0, size_x_r};
    bottom_s  = {1'b0, top_s} + {1'b0, size_y_r};
    size_ok_s = (size_x_r != 10'd0) && (size_x_r <= 10'd32) &&
                (size_y_r != 10'd0) && (size_y_r <= 10'd64);
    inside_s  = size_ok_s &&
                ({1'b0, DrawX} >= {1'b0, left_s}) && ({1'b0, DrawX} < right_s) &&
                ({1'b0, DrawY} >= {1'b0, top_s})  && ({1'b0, DrawY} < bottom_s);
    // Offsets fit in 5/6 bits when inside, so modular low-bit arithmetic is exact.
    dx_off_s  = DrawX[4:0] - left_s[4:0];
    if (inv_r) begin
      col_s = size_x_r[4:0] - 5'd1 - dx_off_s;
    end else begin
      col_s = dx_off_s;
    end
    row_s  = DrawY[5:0] - top_s[5:0];
    addr_s = {anim_slot, row_s, col_s};
  end

  // Registered pixel outputs, one Clk after DrawX/DrawY; address forced to 0 outside the box.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      is_knight   <= 1'b0;
      sprite_addr <= 15'd0;
    end else begin
      is_knight   <= inside_s;
      sprite_addr <= inside_s ? addr_s : 15'd0;
    end
  end

endmodule

`default_nettype wire

// File: doc/knight_animator.md
KNIGHT_ANIMATOR -- requirements
Module: knight_animator

Interface
REQ-001 Clk  in  1  system clock; all state changes on its rising edge.
REQ-002 Reset  in  1  asynchronous, active-high reset.
REQ-003 VS  in  1  VGA vertical sync; a rising edge marks a frame boundary.
REQ-004 DrawX, DrawY  in  10 each  pixel coordinate being drawn, unsigned.
REQ-005 PlayerX, PlayerY  in  10 each  knight centre position, unsigned.
REQ-006 Player_Size_X, Player_Size_Y  in  10 each  knight box size; legal range 1..32 (X) and 1..64 (Y).
REQ-007 Player_Status  in  4  0 idle, 1 walk, 2 jump up, 3 fall, 4 attack; values 5..15 are illegal.
REQ-008 Inverse  in  1  facing direction: 0 right, 1 left (mirror).
REQ-009 is_knight  out  1  current pixel lies inside the knight box.
REQ-010 sprite_addr  out  15  sprite ROM address {slot[3:0], row[5:0], col[4:0]}.
REQ-011 anim_slot  out  4  current animation slot, for debug and HUD.

Function
REQ-012 The block SHALL produce a one-cycle frame_tick on each 0->1 transition of VS, using a registered copy of VS; a steady VS SHALL produce no tick.
REQ-013 On frame_tick, the block SHALL latch Player_Status, Inverse, PlayerX, PlayerY, Player_Size_X and Player_Size_Y; pixel logic SHALL use only the latched copies, so a frame never tears.
REQ-014 An illegal latched status (5..15) SHALL be treated as idle.
REQ-015 Animation FSM states SHALL be IDLE, WALK, JUMP, FALL and ATTACK, selected by the latched status on each frame_tick.
REQ-016 Frame pacing: a 3-bit divider SHALL count frame_ticks and advance frame_idx when it reaches 5, then return to 0, giving one advance every 6 ticks.
REQ-017 On a state change, frame_idx and the divider SHALL both be cleared on that same tick.
REQ-018 IDLE SHALL have 2 frames and WALK 4 frames, both wrapping from the last frame to 0.
REQ-019 JUMP and FALL SHALL each have 1 frame, with frame_idx held at 0.
REQ-020 ATTACK SHALL be a one-shot of 3 frames (0 -> 1 -> 2) that holds frame 2 until the status changes; re-entering ATTACK restarts it at frame 0.
REQ-021 Slot mapping: anim_slot SHALL be:
 - IDLE: 0 + frame_idx
 - WALK: 2 + frame_idx
 - JUMP: 6
 - FALL: 7
 - ATTACK: 8 + frame_idx
 - Slots 11..15 are never produced.
REQ-022 Box edges: left = PlayerX - Player_Size_X/2 and top = PlayerY - Player_Size_Y/2 (truncating division); a subtraction that would go negative SHALL clamp the edge to 0.
REQ-023 Inside test: the pixel is inside when left <= DrawX < left + Player_Size_X and top <= DrawY < top + Player_Size_Y, computed in 11 bits so the sums do not wrap.
REQ-024 Offsets: col = DrawX - left and row = DrawY - top; when Inverse = 1, col SHALL be Player_Size_X - 1 - (DrawX - left).
REQ-025 is_knight and sprite_addr SHALL be registered with a latency of exactly 1 Clk after DrawX/DrawY.
REQ-026 When is_knight = 0, sprite_addr SHALL be 0.
REQ-027 If a latched size is out of range (0, X > 32 or Y > 64), is_knight SHALL be 0 for the whole frame.
REQ-028 A status change and a divider rollover on the same tick: the state change wins and frame_idx = 0.

Reset
REQ-029 While Reset is high, the block SHALL hold: state IDLE, frame_idx 0, divider 0, anim_slot 0, is_knight 0, sprite_addr 0, latched inputs 0, VS history 0.
REQ-030 Reset mid-frame or mid-animation SHALL take effect immediately; the first frame_tick after release SHALL latch fresh inputs.
REQ-031 Between reset release and the first frame_tick, is_knight SHALL be 0, because the latched sizes are 0.

Verification
REQ-032 Status = 1 held for 30 VS pulses -> anim_slot sequence 2,3,4,5,2, each value lasting 6 ticks.
REQ-033 Status = 4 for 24 ticks, then 0 -> anim_slot 8,9,10 (6 ticks each), then held at 10, then 0 on the tick where status becomes 0.
REQ-034 Latched PlayerX = 320, PlayerY = 377, size 30x62, Inverse = 0; drive DrawX = 305, DrawY = 346 -> is_knight = 1 and sprite_addr = {0, 0, 0} one cycle later. DrawX = 335 -> is_knight = 0.
REQ-035 Same position with Inverse = 1 and DrawX = 305 -> col = 29; DrawX = 334 -> col = 0.
REQ-036 PlayerX = 5, size 30 -> left = 0 (clamped); DrawX = 0 -> is_knight = 1. Status = 9 -> anim_slot 0 or 1 (IDLE).
REQ-037 Assert Reset while in WALK frame 3 -> all outputs 0 in the same cycle; after release, the next VS rising edge with status = 1 -> anim_slot 2.
